sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Time-multiplexed scan controller for the weighing-scale front-panel display. Holds a DIGITS-wide hex word and presents one nibble at a time to the shared hex-to-seven-segment decoder, with a one-hot active-low digit strobe. Applies leading-zero blanking and decimal-point placement. Accepts display updates without tearing: a new word is committed only at a frame boundary.

## Interface
- DIGITS, 4: number of digit positions, 2..8. Index DIGITS-1 is leftmost (most significant).
- CLK_DIV, 50000: clock cycles per digit slot, at least 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle update strobe; samples value, dp_en and dp_idx.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i.
- dp_en  in  1  decimal point enable.
- dp_idx  in  clog2(DIGITS)  digit whose decimal point is lit.
- blank_lz  in  1  leading-zero blanking enable; level input, sampled every cycle.
- hex  out  4  nibble to the decoder; 4'hF is the decoder's blank code.
- digit_sel  out  DIGITS  active-low one-hot digit enable.
- dp  out  1  decimal point for the active digit, active high.
- upd_ack  out  1  one-cycle pulse when a loaded word is committed.
- frame_tick  out  1  one-cycle pulse when a new frame starts.

## Operation
- Registers:
  - prescaler cnt: 0..CLK_DIV-1.
  - digit index idx: DIGITS-1 down to 0, then wraps to DIGITS-1.
  - shadow word, shadow dp, pending flag.
  - active word, active dp.
  - nz flag: a nonzero digit has been shown this frame.
- Reset state:
  - cnt=0, idx=DIGITS-1, pending=0, nz=0.
  - Shadow and active words all 4'hF; dp_en latched 0.
  - Outputs: hex=4'hF, digit_sel all ones, dp=0, upd_ack=0, frame_tick=0.
  - Display is dark until the first commit.
- Scan: cnt increments every cycle. At cnt==CLK_DIV-1, cnt returns to 0 and idx decrements, wrapping 0 to DIGITS-1.
- Frame boundary: the cycle where cnt==CLK_DIV-1 and idx==0. On the next edge:
  - frame_tick pulses.
  - nz clears.
  - If pending is set, active takes shadow, pending clears and upd_ack pulses.
- Load:
  - On load, shadow takes value/dp_en/dp_idx and pending sets.
  - A second load before commit overwrites shadow; only the last value commits, with one upd_ack.
- Load coinciding with the frame boundary: value/dp is written directly into active, upd_ack pulses, and pending ends 0.
- Blanking rule for the digit at idx, with nibble n = active[idx]:
  - The digit is shown as 4'hF when blank_lz=1, n==0, nz==0, idx!=0, and not (dp_en && idx<=dp_idx).
  - Otherwise hex=n, and nz sets if n!=0 or the digit is shown.
  - Digit 0 is never blanked. Digits at or right of the decimal point are never blanked.
- dp = dp_en && (idx==dp_idx) during the digit's active cycles; otherwise 0.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Ghost guard: the cycle where registered cnt==0 has digit_sel all ones and dp=0.
  - hex is updated on the same edge that enters this cycle, so the new digit's nibble is present one cycle before its strobe.
- Active window: for cnt 1..CLK_DIV-1, bit idx of digit_sel is 0 and all other bits are 1. Each digit is lit CLK_DIV-1 cycles per slot.
- Frame period is DIGITS*CLK_DIV cycles. frame_tick and upd_ack, when it fires, coincide with the ghost-guard cycle of digit DIGITS-1.
- Load-to-display latency:
  - Minimum is 1 cycle, when load coincides with the boundary.
  - Maximum is DIGITS*CLK_DIV cycles.
- Asynchronous reset mid-frame returns immediately to the reset state. Any pending word is discarded and no upd_ack is issued.
- load while rst_n is low is ignored.

## Test plan
(DIGITS=4, CLK_DIV=4.)
- Reset, then idle 32 cycles:
  - hex stays F and upd_ack stays 0.
  - frame_tick pulses every 16 cycles.
  - digit_sel cycles 0111, 1011, 1101, 1110; each strobe lasts 3 cycles, separated by one 1111 cycle.
- load value=16'h0042, blank_lz=1, dp_en=0:
  - One upd_ack, in the same cycle as frame_tick.
  - Next frame hex sequence is F, F, 4, 2.
- Same load with dp_en=1, dp_idx=2: hex sequence is F, 0, 4, 2, with dp=1 only during digit 2's active window.
- blank_lz=0 with value 16'h0000: hex is 0, 0, 0, 0. With blank_lz=1: F, F, F, 0.
- Two loads (16'h1111, then 16'h2222) within one frame: exactly one upd_ack, and the display shows 2222.
- Load 16'h1234 exactly at a boundary cycle: upd_ack on the next edge, and 1234 shown in that frame.
- Assert rst_n low mid-frame with pending=1: all outputs return to reset values within the same cycle, and no commit follows release.

Source files
------------

// File: rtl/sseg_if.sv
// Display-update and scan-output bundle shared by the scan controller and its host.
// The host drives the update side; the controller drives the decoder/strobe side.
interface sseg_if #(
  parameter int DIGITS = 4
);
  localparam int IW = $clog2(DIGITS);

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  dp_en;
  logic [IW-1:0]         dp_idx;
  logic                  blank_lz;
  logic [3:0]            hex;
  logic [DIGITS-1:0]     digit_sel;
  logic                  dp;
  logic                  upd_ack;
  logic                  frame_tick;

  modport master (
    output load, value, dp_en, dp_idx, blank_lz,
    input  hex, digit_sel, dp, upd_ack, frame_tick
  );

  modport slave (
    input  load, value, dp_en, dp_idx, blank_lz,
    output hex, digit_sel, dp, upd_ack, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with leading-zero blanking,
// decimal-point placement and tear-free updates committed at frame boundaries.
module sseg_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic  clk,
  input  logic  rst_n,
  sseg_if.slave bus
);
  localparam int              CW      = $clog2(CLK_DIV);
  localparam int              IW      = $clog2(DIGITS);
  localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IDX_TOP = IW'(DIGITS - 1);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] word;
    logic                   dp_en;
    logic [IW-1:0]          dp_idx;
  } disp_t;

  localparam disp_t DISP_DARK = '{word: '1, dp_en: 1'b0, dp_idx: '0};

  logic [CW-1:0]     cnt, cnt_next;
  logic [IW-1:0]     idx, idx_next;
  disp_t             shadow, active, active_next, incoming;
  logic              pending, pending_next;
  logic              nz, nz_next;
  logic              slot_end, boundary, blank, ack_next, dp_next;
  logic [3:0]        nib, hex_next;
  logic [DIGITS-1:0] sel_next;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    incoming     = '{word: bus.value, dp_en: bus.dp_en, dp_idx: bus.dp_idx};
    slot_end     = (cnt == CNT_MAX);
    boundary     = slot_end && (idx == '0);
    cnt_next     = slot_end ? '0 : cnt + CW'(1);
    idx_next     = idx;
    active_next  = active;
    pending_next = pending;
    ack_next     = 1'b0;
    nz_next      = nz;

    if (slot_end) idx_next = (idx == '0) ? IDX_TOP : idx - IW'(1);

    // A load landing on the boundary bypasses the shadow so it shows this frame.
    if (boundary && bus.load) begin
      active_next  = incoming;
      pending_next = 1'b0;
      ack_next     = 1'b1;
    end else if (boundary && pending) begin
      active_next  = shadow;
      pending_next = 1'b0;
      ack_next     = 1'b1;
    end else if (bus.load) begin
      pending_next = 1'b1;
    end

    // Digit evaluation happens on the edge entering a slot; nz restarts each frame.
    nib   = active_next.word[idx_next];
    blank = bus.blank_lz && (nib == 4'h0) && !(nz && !boundary) && (idx_next != '0)
            && !(active_next.dp_en && (idx_next <= active_next.dp_idx));
    hex_next = blank ? 4'hF : nib;
    if (slot_end) nz_next = !blank;

    // Strobe stays dark during the first cycle of each slot while hex settles.
    sel_next = '1;
    if (cnt_next != '0) sel_next[idx_next] = 1'b0;
    dp_next = (cnt_next != '0) && active_next.dp_en && (idx_next == active_next.dp_idx);
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  // NOTE: shadow/active words are reset (not left as uninitialised storage) so the display is dark until the first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= IDX_TOP;
      shadow         <= DISP_DARK;
      active         <= DISP_DARK;
      pending        <= 1'b0;
      nz             <= 1'b0;
      bus.hex        <= 4'hF;
      bus.digit_sel  <= '1;
      bus.dp         <= 1'b0;
      bus.upd_ack    <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_next;
      idx            <= idx_next;
      active         <= active_next;
      pending        <= pending_next;
      nz             <= nz_next;
      if (bus.load && !boundary) shadow <= incoming;
      if (slot_end) bus.hex <= hex_next;
      bus.digit_sel  <= sel_next;
      bus.dp         <= dp_next;
      bus.upd_ack    <= ack_next;
      bus.frame_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (DIGITS=4, CLK_DIV=4): directed steps from
// the display requirements followed by randomized updates against a frame-level model.
module tb_sseg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  sseg_if #(.DIGITS(4)) bus ();

  sseg_scan_ctrl #(.DIGITS(4), .CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: k counts clock edges since reset release; slot and digit follow from k.
  int          k;
  logic [15:0] m_word, s_word;
  logic        m_dpen, s_dpen, m_pend;
  logic [1:0]  m_dpidx, s_dpidx;
  logic [3:0]  m_hex, m_sel;
  logic        m_dp, m_ack, m_tick;
  int          n_ack, n_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; m_word = 16'hFFFF; s_word = 16'hFFFF; m_dpen = 0; s_dpen = 0;
    m_dpidx = 0; s_dpidx = 0; m_pend = 0;
    m_hex = 4'hF; m_sel = 4'hF; m_dp = 0; m_ack = 0; m_tick = 0;
  endtask

  // A digit is blanked when it and every digit to its left are zero, unless it is
  // digit 0 or sits at/right of the lit decimal point.
  function automatic logic [3:0] shown(input int d);
    logic [3:0] n;
    bit lead;
    n = m_word[4*d +: 4];
    lead = 1;
    for (int j = 3; j >= d; j--) if (m_word[4*j +: 4] != 4'h0) lead = 0;
    if (bus.blank_lz && lead && d != 0 && !(m_dpen && d <= int'(m_dpidx))) return 4'hF;
    return n;
  endfunction

  task automatic model_edge(input logic ld, input logic [15:0] v, input logic de, input logic [1:0] di);
    int c, d;
    k++;
    m_tick = (k % 16 == 0);
    m_ack  = 0;
    if (m_tick) begin
      if (ld) begin
        m_word = v; m_dpen = de; m_dpidx = di; m_ack = 1; m_pend = 0;
      end else if (m_pend) begin
        m_word = s_word; m_dpen = s_dpen; m_dpidx = s_dpidx; m_ack = 1; m_pend = 0;
      end
    end else if (ld) begin
      s_word = v; s_dpen = de; s_dpidx = di; m_pend = 1;
    end
    c = k % 4;
    d = 3 - (k / 4) % 4;
    if (c == 0) m_hex = shown(d);
    m_sel = (c == 0) ? 4'hF : ~(4'b0001 << d);
    m_dp  = (c != 0) && m_dpen && (d == int'(m_dpidx));
  endtask

  task automatic compare();
    check("hex", 32'(bus.hex), 32'(m_hex));
    check("digit_sel", 32'(bus.digit_sel), 32'(m_sel));
    check("dp", 32'(bus.dp), 32'(m_dp));
    check("upd_ack", 32'(bus.upd_ack), 32'(m_ack));
    check("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex"}, 32'(bus.hex), 32'hF);
    check({tag, "_sel"}, 32'(bus.digit_sel), 32'hF);
    check({tag, "_dp"}, 32'(bus.dp), 32'h0);
    check({tag, "_ack"}, 32'(bus.upd_ack), 32'h0);
    check({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic de, input logic [1:0] di);
    bus.load = ld; bus.value = v; bus.dp_en = de; bus.dp_idx = di;
    @(posedge clk);
    model_edge(ld, v, de, di);
    #1;
    bus.load = 1'b0;
    compare();
    if (bus.upd_ack) n_ack++;
    if (bus.frame_tick) n_tick++;
  endtask

  // Runs to the cycle before a boundary, sets blank_lz, then records one whole frame.
  task automatic capture(input logic bl, input logic ld, input logic [15:0] v, input logic de,
                         input logic [1:0] di, output logic [15:0] seq, output int acks, output int dps);
    int guard;
    guard = 0;
    while ((k + 1) % 16 != 0 && guard < 16) begin
      step(0, 16'h0, 0, 2'd0);
      guard++;
    end
    bus.blank_lz = bl;
    seq = 16'h0; acks = 0; dps = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) step(ld, v, de, di);
      else step(0, 16'h0, 0, 2'd0);
      if (i % 4 == 0) seq = {seq[11:0], bus.hex};
      if (bus.upd_ack) acks++;
      if (bus.dp) dps++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq;
    int acks, dps, a0, t0;
    logic [15:0] rv;

    bus.load = 0; bus.value = 16'h0; bus.dp_en = 0; bus.dp_idx = 0; bus.blank_lz = 1'b1;
    n_ack = 0; n_tick = 0;
    model_reset();
    #22;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle after reset: dark display, ticks every 16 cycles, no acks.
    a0 = n_ack; t0 = n_tick;
    repeat (32) step(0, 16'h0, 0, 2'd0);
    check("idle_ticks", 32'(n_tick - t0), 32'd2);
    check("idle_acks", 32'(n_ack - a0), 32'd0);

    // Mid-frame load commits at the next boundary with leading zeros blanked.
    step(1, 16'h0042, 0, 2'd0);
    capture(1, 0, 16'h0, 0, 2'd0, seq, acks, dps);
    check("lz_seq", 32'(seq), 32'hFF42);
    check("lz_acks", 32'(acks), 32'd1);

    // Decimal point on digit 2 protects it from blanking.
    step(1, 16'h0042, 1, 2'd2);
    capture(1, 0, 16'h0, 0, 2'd0, seq, acks, dps);
    check("dp_seq", 32'(seq), 32'hF042);
    check("dp_cycles", 32'(dps), 32'd3);

    // All zeros without and with blanking.
    capture(0, 1, 16'h0000, 0, 2'd0, seq, acks, dps);
    check("zero_noblank_seq", 32'(seq), 32'h0000);
    capture(1, 0, 16'h0, 0, 2'd0, seq, acks, dps);
    check("zero_blank_seq", 32'(seq), 32'hFFF0);

    // Two loads within one frame: only the last commits, once.
    a0 = n_ack;
    step(0, 16'h0, 0, 2'd0);
    step(1, 16'h1111, 0, 2'd0);
    step(0, 16'h0, 0, 2'd0);
    step(1, 16'h2222, 0, 2'd0);
    capture(1, 0, 16'h0, 0, 2'd0, seq, acks, dps);
    check("double_seq", 32'(seq), 32'h2222);
    check("double_acks", 32'(n_ack - a0), 32'd1);

    // Load exactly on the boundary cycle shows in the frame that starts on that edge.
    capture(1, 1, 16'h1234, 0, 2'd0, seq, acks, dps);
    check("bnd_seq", 32'(seq), 32'h1234);
    check("bnd_acks", 32'(acks), 32'd1);

    // Asynchronous reset mid-frame with a pending word: word discarded, no commit later.
    step(0, 16'h0, 0, 2'd0);
    step(0, 16'h0, 0, 2'd0);
    step(1, 16'h5678, 1, 2'd1);
    repeat (3) step(0, 16'h0, 0, 2'd0);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    bus.load = 1'b1; bus.value = 16'h9999;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    #3 rst_n = 1'b1;
    bus.load = 1'b0;
    a0 = n_ack;
    repeat (40) step(0, 16'h0, 0, 2'd0);
    check("post_rst_acks", 32'(n_ack - a0), 32'd0);
    check("post_rst_hex", 32'(bus.hex), 32'hF);

    // Randomized updates; blank_lz only changes ahead of a frame boundary.
    for (int i = 0; i < 640; i++) begin
      for (int j = 0; j < 4; j++)
        rv[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ((k + 1) % 16 == 0) bus.blank_lz = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 7) == 0), rv, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
